// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Byte-stream program loader. It takes an origin word, a count
//               word and then count data words (each MSB byte first), and it
//               issues a one-cycle memory write for each data word.
//               Define LOADER_CHECKSUM_EN to require a trailing sum-of-data
//               checksum word.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] address_out,
    output logic [15:0] data_out,
    output logic        we_out,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tw-1:0] c_idle_max = c_tw'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] c_st_idle    = 4'd0;
    localparam logic [3:0] c_st_org_hi  = 4'd1;
    localparam logic [3:0] c_st_org_lo  = 4'd2;
    localparam logic [3:0] c_st_cnt_hi  = 4'd3;
    localparam logic [3:0] c_st_cnt_lo  = 4'd4;
    localparam logic [3:0] c_st_data_hi = 4'd5;
    localparam logic [3:0] c_st_data_lo = 4'd6;
    localparam logic [3:0] c_st_write   = 4'd7;
    localparam logic [3:0] c_st_done    = 4'd8;
    localparam logic [3:0] c_st_error   = 4'd9;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [3:0] c_st_chk_hi  = 4'd10;
    localparam logic [3:0] c_st_chk_lo  = 4'd11;
    localparam logic [3:0] c_st_complete = c_st_chk_hi;
`else
    localparam logic [3:0] c_st_complete = c_st_done;
`endif

    logic [3:0]      r_state;
    logic [15:0]     r_origin;
    logic [15:0]     r_count;
    logic [15:0]     r_index;
    logic [7:0]      r_hi;
    logic [15:0]     r_addr;
    logic [15:0]     r_data;
    logic [c_tw-1:0] r_idle;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]     r_sum;
`endif

    logic        w_rx;
    logic        w_accept;
    logic [15:0] w_word;
    logic [15:0] w_next_index;

    always_comb begin
        w_rx = 1'b0;
        case (r_state)
            c_st_org_hi, c_st_org_lo, c_st_cnt_hi, c_st_cnt_lo,
            c_st_data_hi, c_st_data_lo: w_rx = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            c_st_chk_hi, c_st_chk_lo:   w_rx = 1'b1;
`endif
            default:                    w_rx = 1'b0;
        endcase
    end

    assign w_accept     = w_rx & byte_valid;
    assign w_word       = {r_hi, byte_in};
    assign w_next_index = r_index + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_origin <= 16'd0;
            r_count  <= 16'd0;
            r_index  <= 16'd0;
            r_hi     <= 8'd0;
            r_addr   <= 16'd0;
            r_data   <= 16'd0;
            r_idle   <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum    <= 16'd0;
`endif
        end else if (w_rx) begin
            if (w_accept) begin
                r_idle <= '0;
                case (r_state)
                    c_st_org_hi: begin
                        r_hi    <= byte_in;
                        r_state <= c_st_org_lo;
                    end
                    c_st_org_lo: begin
                        r_origin <= w_word;
                        r_state  <= c_st_cnt_hi;
                    end
                    c_st_cnt_hi: begin
                        r_hi    <= byte_in;
                        r_state <= c_st_cnt_lo;
                    end
                    c_st_cnt_lo: begin
                        r_count <= w_word;
                        r_state <= (w_word == 16'd0) ? c_st_complete : c_st_data_hi;
                    end
                    c_st_data_hi: begin
                        r_hi    <= byte_in;
                        r_state <= c_st_data_lo;
                    end
                    c_st_data_lo: begin
                        // Address wraps naturally at 16 bits
                        r_addr  <= r_origin + r_index;
                        r_data  <= w_word;
`ifdef LOADER_CHECKSUM_EN
                        r_sum   <= r_sum + w_word;
`endif
                        r_state <= c_st_write;
                    end
`ifdef LOADER_CHECKSUM_EN
                    c_st_chk_hi: begin
                        r_hi    <= byte_in;
                        r_state <= c_st_chk_lo;
                    end
                    c_st_chk_lo: begin
                        r_state <= (w_word == r_sum) ? c_st_done : c_st_error;
                    end
`endif
                    default: r_state <= c_st_idle;
                endcase
            end else if (r_idle == c_idle_max) begin
                r_state <= c_st_error;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end else begin
            case (r_state)
                c_st_idle, c_st_done, c_st_error: begin
                    if (start) begin
                        r_state <= c_st_org_hi;
                        r_index <= 16'd0;
                        r_idle  <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_sum   <= 16'd0;
`endif
                    end
                end
                c_st_write: begin
                    r_index <= w_next_index;
                    r_state <= (w_next_index == r_count) ? c_st_complete : c_st_data_hi;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign byte_ready  = w_rx;
    assign we_out      = (r_state == c_st_write);
    assign address_out = r_addr;
    assign data_out    = r_data;
    assign done        = (r_state == c_st_done);
    assign error       = (r_state == c_st_error);
    assign busy        = !((r_state == c_st_idle) || (r_state == c_st_done) ||
                           (r_state == c_st_error));

endmodule
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 50000; maximum number of idle clk cycles allowed between accepted bytes.
REQ-002 Port: clk  in  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE or ERROR.
REQ-005 Port: byte_in  in  8  serial-receiver byte.
REQ-006 Port: byte_valid  in  1  byte_in is valid this cycle.
REQ-007 Port: byte_ready  out  1  loader accepts a byte; transfer occurs when byte_valid and byte_ready are both high.
REQ-008 Port: address_out  out  16  memory write address; drives the memory direct-port address.
REQ-009 Port: data_out  out  16  memory write data; drives the memory direct-port data.
REQ-010 Port: we_out  out  1  memory write enable; one-cycle pulse per word.
REQ-011 Port: busy  out  1  high in every state except IDLE, DONE and ERROR.
REQ-012 Port: done  out  1  level; load completed successfully.
REQ-013 Port: error  out  1  level; load aborted by timeout or checksum mismatch.

Function
REQ-014 The stream format SHALL be: origin word, count word, then count data words; every word is sent MSB byte first.
REQ-015 The states SHALL be IDLE, ORG_HI, ORG_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, DONE and ERROR (plus CHK_HI and CHK_LO per REQ-029).
REQ-016 Transitions from IDLE, DONE or ERROR: start -> ORG_HI; also clear done, error, the word index and the running sum.
REQ-017 Each receive state SHALL advance to the next state on an accepted byte and hold otherwise.
REQ-018 Sequence: ORG_HI -> ORG_LO -> CNT_HI -> CNT_LO.
REQ-019 From CNT_LO, on acceptance: count==0 -> DONE (or CHK_HI when checksum enabled); otherwise -> DATA_HI.
REQ-020 From DATA_HI: -> DATA_LO. From DATA_LO: -> WRITE.
REQ-021 WRITE SHALL last exactly one cycle, with we_out=1, address_out=(origin+index) mod 2^16 and data_out equal to the assembled word.
REQ-022 After WRITE, index increments; if index==count -> DONE (or CHK_HI), else -> DATA_HI.
REQ-023 byte_ready SHALL be 1 only in the receive states (ORG_*, CNT_*, DATA_*, CHK_*) and 0 in WRITE, IDLE, DONE and ERROR.
REQ-024 Address wrap-around past 16'hFFFF SHALL continue at 16'h0000 without error.
REQ-025 An idle counter SHALL clear on each accepted byte and on start, and increment in receive states; reaching TIMEOUT_CYCLES -> ERROR with no further writes.
REQ-026 start asserted while busy SHALL be ignored.
REQ-027 Outside WRITE, we_out SHALL be 0; address_out and data_out hold their last values.

Reset
REQ-028 reset SHALL immediately force IDLE and set all outputs to 0, including byte_ready, we_out, busy, done and error; an in-progress load is abandoned with no write issued.

Configuration
REQ-029 With macro LOADER_CHECKSUM_EN defined, the count-complete path SHALL go to CHK_HI -> CHK_LO. A received 16-bit word equal to the sum of all data words mod 2^16 -> DONE; a mismatch -> ERROR (words already written remain in memory).
REQ-030 With LOADER_CHECKSUM_EN undefined, the CHK states and the running-sum logic SHALL not exist, and the count-complete path goes directly to DONE.

Verification
REQ-031 Bytes 30 00 00 02 12 34 AB CD -> writes (3000,1234) then (3001,ABCD), each with a one-cycle we_out; done=1 afterwards.
REQ-032 Origin FFFF, count 2, data 0001 0002 -> writes at FFFF then 0000; done=1.
REQ-033 Count 0000 -> no we_out, done=1 (with LOADER_CHECKSUM_EN, a checksum of 0000 is also required).
REQ-034 TIMEOUT_CYCLES=16, stream stops after the origin bytes -> error=1 after 16 idle cycles, busy=0, no we_out.
REQ-035 reset asserted between DATA_HI and DATA_LO -> all outputs 0 at once; a following start plus a full stream loads correctly.
REQ-036 LOADER_CHECKSUM_EN, data 0001 0002 with checksum 0004 -> two writes, then error=1; the same stream with checksum 0003 -> done=1.
